// File: rtl/bf_iteration_ctrl.sv
// bf_iteration_ctrl: sequencing and convergence controller for the 8-node Bellman-Ford datapath.
//
// Optional feature macro: BF_CTRL_EARLY_EXIT_EN
//   defined   - a snapshot of the distance vector is taken at every rollover; an
//               iteration that changes no distance ends the run early.
//   undefined - no snapshot or comparators; a run ends only at the MAX_ITER cap
//               and converged is tied 0.
//
// Ports:
//   clk                    in   single clock, rising edge
//   rst_global             in   asynchronous active-low reset
//   start                  in   run start pulse, honoured only in IDLE and DONE
//   rollover_phase_counter in   datapath end-of-iteration pulse
//   finish                 in   datapath completion level
//   d_0000..d_0007         in   current node distances, all-ones is infinity
//   write_enable           out  datapath load strobe, LOAD_CYCLES cycles long
//   read_enable            out  datapath run enable
//   iteration_done         out  one-cycle terminate request, decoded from flops only
//   done                   out  run complete, held until the next start
//   converged              out  1 = early exit on no change, 0 = cap reached
//   iter_count             out  completed iterations
//   err                    out  sticky, rollover seen during CHECK
module bf_iteration_ctrl #(
  parameter int N_NODES     = 8,
  parameter int DW          = 32,
  parameter int LOAD_CYCLES = 2,
  parameter int MAX_ITER    = 2047
) (
  input  logic          clk,
  input  logic          rst_global,
  input  logic          start,
  input  logic          rollover_phase_counter,
  input  logic          finish,
  input  logic [DW-1:0] d_0000,
  input  logic [DW-1:0] d_0001,
  input  logic [DW-1:0] d_0002,
  input  logic [DW-1:0] d_0003,
  input  logic [DW-1:0] d_0004,
  input  logic [DW-1:0] d_0005,
  input  logic [DW-1:0] d_0006,
  input  logic [DW-1:0] d_0007,
  output logic          write_enable,
  output logic          read_enable,
  output logic          iteration_done,
  output logic          done,
  output logic          converged,
  output logic [10:0]   iter_count,
  output logic          err
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_WAIT_FIN = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [10:0] ITER_CAP = 11'(MAX_ITER);
  logic [2:0]    state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [10:0]   iter_count_q, iter_count_d;
  logic          err_q, err_d;
  logic          restart, cap_hit, changed, exit_chk;
  assign restart  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign cap_hit  = (iter_count_q + 11'd1) == ITER_CAP;
  // Exit decision uses only registered state so iteration_done is glitch-free.
  assign exit_chk = (state_q == S_CHECK) && (!changed || cap_hit);
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    iter_count_d = iter_count_q;
    err_d        = err_q;
    if (restart) begin
      state_d      = S_LOAD;
      load_cnt_d   = '0;
      iter_count_d = '0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          load_cnt_d = load_cnt_q + 1'b1;
          state_d    = (load_cnt_q == LOAD_LAST) ? S_RUN : S_LOAD;
        end
        S_RUN:      state_d = rollover_phase_counter ? S_CHECK : S_RUN;
        S_CHECK: begin
          // A rollover here is a datapath protocol violation: flag it, don't count it.
          iter_count_d = (iter_count_q == ITER_CAP) ? iter_count_q : iter_count_q + 11'd1;
          err_d        = err_q | rollover_phase_counter;
          state_d      = exit_chk ? S_WAIT_FIN : S_RUN;
        end
        S_WAIT_FIN: state_d = finish ? S_DONE : S_WAIT_FIN;
        S_IDLE, S_DONE: ;
        default:    state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      iter_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      iter_count_q <= iter_count_d;
      err_q        <= err_d;
    end
  end
`ifdef BF_CTRL_EARLY_EXIT_EN
  logic [N_NODES-1:0][DW-1:0] d, snap_q, snap_d;
  logic                       changed_q, changed_d;
  logic                       converged_q, converged_d;
  assign d = {d_0007, d_0006, d_0005, d_0004, d_0003, d_0002, d_0001, d_0000};
  always_comb begin
    snap_d      = snap_q;
    changed_d   = changed_q;
    converged_d = converged_q;
    if (restart) begin
      snap_d      = '1;
      converged_d = 1'b0;
    end else if (state_q == S_RUN && rollover_phase_counter) begin
      changed_d = 1'b0;
      for (int i = 0; i < N_NODES; i++) begin
        changed_d = changed_d | (d[i] != snap_q[i]);
        snap_d[i] = d[i];
      end
    end else if (exit_chk && !changed_q) begin
      converged_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) begin
      snap_q      <= '1;
      changed_q   <= 1'b0;
      converged_q <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      changed_q   <= changed_d;
      converged_q <= converged_d;
    end
  end
  assign changed   = changed_q;
  assign converged = converged_q;
`else
  logic unused_d;
  assign unused_d  = ^{d_0000, d_0001, d_0002, d_0003, d_0004, d_0005, d_0006, d_0007};
  assign changed   = 1'b1;
  assign converged = 1'b0;
`endif
  assign write_enable   = state_q == S_LOAD;
  assign read_enable    = state_q == S_RUN || state_q == S_CHECK || state_q == S_WAIT_FIN;
  assign iteration_done = exit_chk;
  assign done           = state_q == S_DONE;
  assign iter_count     = iter_count_q;
  assign err            = err_q;
endmodule

// File: doc/bf_iteration_ctrl.md
# bf_iteration_ctrl

- Sequencing and convergence controller directly upstream of the 8-node Bellman-Ford datapath.
- Drives the datapath's `write_enable`, `read_enable` and `iteration_done` inputs, and watches its `rollover_phase_counter`, `finish` and `d_0000`..`d_0007` outputs.
- Snapshots the distance vector at every phase rollover and ends the run when an iteration changes no distance, or when the iteration cap is hit.

## Interface
- `N_NODES`, 8: number of distance ports; fixed at 8 for this array.
- `DW`, 32: distance width. All-ones means infinity.
- `LOAD_CYCLES`, 2: cycles `write_enable` is held high to load initial weights.
- `MAX_ITER`, 2047: iteration cap; fits the datapath's 11-bit iteration counter.
- `clk`, in, 1: single clock, rising edge.
- `rst_global`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a run; ignored outside IDLE and DONE.
- `rollover_phase_counter`, in, 1: datapath end-of-iteration pulse.
- `finish`, in, 1: datapath completion flag.
- `d_0000`..`d_0007`, in, DW each: current node distances.
- `write_enable`, out, 1: datapath load strobe.
- `read_enable`, out, 1: datapath run enable.
- `iteration_done`, out, 1: one-cycle terminate request to the datapath.
- `done`, out, 1: run complete; held high.
- `converged`, out, 1: 1 = early exit on no change; 0 = cap reached.
- `iter_count`, out, 11: number of completed iterations.
- `err`, out, 1: sticky; set when a rollover arrives during CHECK.

## Operation
- States: IDLE, LOAD, RUN, CHECK, WAIT_FIN, DONE.
- IDLE:
  - All outputs 0.
  - `start` -> LOAD. On entry to LOAD: clear `iter_count`, `converged`, `done`, `err`; set all snapshot registers to all-ones.
- LOAD:
  - `write_enable`=1 for exactly LOAD_CYCLES cycles, then -> RUN.
- RUN:
  - `read_enable`=1.
  - On `rollover_phase_counter`=1, at that edge:
    - compare each `d_i` against snapshot_i;
    - register `changed` = OR of all mismatches;
    - load the snapshot with the current `d_i`;
    - -> CHECK.
- CHECK (exactly one cycle):
  - `read_enable` stays 1.
  - `iter_count` increments at the exit edge, saturating at MAX_ITER.
  - Exit condition:
    - early exit if `changed`=0, with `converged`=1 registered at the exit edge;
    - or cap exit if `iter_count`+1 == MAX_ITER.
  - Exit condition true: `iteration_done`=1 this cycle, -> WAIT_FIN.
  - Otherwise -> RUN.
  - A rollover during CHECK is not counted and sets `err`.
- WAIT_FIN:
  - `read_enable`=1; rollovers ignored.
  - `finish`=1 -> DONE.
- DONE:
  - `read_enable`=0, `write_enable`=0, `done`=1.
  - `iter_count`, `converged` and the snapshot are held.
  - `start` -> LOAD; this clears everything as on entry from IDLE.
- Comparison is exact DW-bit equality. No arithmetic on distances.
- The first rollover after LOAD always sees `changed`=1 unless every `d_i` is all-ones.

## Timing
- Reset (asynchronous, `rst_global`=0):
  - state = IDLE;
  - every output = 0;
  - snapshot = all-ones;
  - `iter_count` = 0.
- Reset mid-run aborts immediately. No pulse is emitted.
- `start` sampled at edge k -> `write_enable` high in cycles k+1 .. k+LOAD_CYCLES -> `read_enable` high from k+LOAD_CYCLES+1.
- Rollover sampled at edge k -> CHECK occupies cycle k+1. `iteration_done` (if asserted) is high only in cycle k+1, driven from registers only.
- `finish` sampled at edge j -> `done`=1 from cycle j+1.
- `finish` arriving in the same cycle as the CHECK exit is sampled in WAIT_FIN on the next edge; it is not lost because `finish` is level.
- The datapath guarantees rollovers are at least 2 cycles apart.

## Configuration
- Macro: `BF_CTRL_EARLY_EXIT_EN`.
- Defined:
  - convergence detection as above;
  - snapshot registers (N_NODES x DW) and comparators present.
- Undefined:
  - snapshot and comparators removed; `changed` is treated as constant 1;
  - exit only on the MAX_ITER cap;
  - `converged` tied 0.

## Test plan
- **Reset and load:** reset, then `start` at cycle 5 -> `write_enable`=1 in cycles 6–7, `read_enable` rises at cycle 8, all other outputs 0.
- **Early exit:** distances change across rollovers 1–3, stay equal at rollover 4 -> `iteration_done` one cycle after rollover 4, `iter_count`=4, `converged`=1. Then `finish` -> `done`=1.
- **Cap exit:** MAX_ITER=5, distances change at every rollover -> `iteration_done` after rollover 5, `iter_count`=5, `converged`=0.
- **Misplaced rollover:** rollover pulse during CHECK -> `err`=1 and sticky; `iter_count` not incremented for it.
- **Reset mid-run:** `rst_global` low during RUN -> all outputs 0 immediately. A subsequent `start` runs cleanly from `iter_count`=0.
- **Macro undefined:** constant distances, MAX_ITER=3 -> no early exit, `iteration_done` after rollover 3, `converged`=0.
